// File: rtl/riscv_pkg.sv
// Shared definitions for the RV64 pipeline: widths, opcodes,
// ALUOp encodings and the decoded control bundle.
package riscv_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: sign-extends the I/S/B immediate selected by
// opcode; every other opcode yields zero.
module decode_stage_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [6:0] opcode;

    assign opcode = instr[6:0];

    always_comb begin
        imm = '0;
        unique case (1'b1)
            (opcode == OP_IMM),
            (opcode == OP_LOAD):
                imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            (opcode == OP_STORE):
                imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            (opcode == OP_BRANCH):
                imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV64 instruction-decode stage: register read addressing, control and
// immediate decode, write-back bypass and the ID/EX pipeline register.
module decode_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    input  logic            wb_RegWrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_RegWrite,
    output logic            ex_MemRead,
    output logic            ex_MemWrite,
    output logic            ex_MemtoReg,
    output logic            ex_ALUSrc,
    output logic            ex_Branch,
    output logic [1:0]      ex_ALUOp,
    output logic [3:0]      ex_funct,
    output logic            ex_illegal
);

    logic [6:0]      opcode;
    ctrl_t           ctrl;
    ctrl_t           ex_ctrl;
    logic            has_rd;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign opcode = if_instr[6:0];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = has_rd ? if_instr[11:7] : 5'd0;

    assign id_ready = !ex_valid || ex_ready;

    always_comb begin
        ctrl   = '0;
        has_rd = 1'b0;
        unique case (1'b1)
            (opcode == OP_R): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_R;
                has_rd         = 1'b1;
            end
            (opcode == OP_IMM): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_I;
                has_rd         = 1'b1;
            end
            (opcode == OP_LOAD): begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                has_rd          = 1'b1;
            end
            (opcode == OP_STORE): begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            (opcode == OP_BRANCH): begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_BR;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    decode_stage_imm_gen u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    // Register file writes at the same edge we capture, so bypass it.
    always_comb begin
        op1 = ReadData1;
        op2 = ReadData2;
        if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rs1) op1 = wb_data;
        if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rs2) op2 = wb_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (id_ready) begin
            ex_valid <= if_valid;
            if (if_valid) begin
                ex_ctrl     <= ctrl;
                ex_pc       <= if_pc;
                ex_rs1_data <= op1;
                ex_rs2_data <= op2;
                ex_imm      <= imm;
                ex_rd       <= rd;
                ex_funct    <= {if_instr[30], if_instr[14:12]};
            end
        end
    end

    assign ex_RegWrite = ex_ctrl.reg_write;
    assign ex_MemRead  = ex_ctrl.mem_read;
    assign ex_MemWrite = ex_ctrl.mem_write;
    assign ex_MemtoReg = ex_ctrl.mem_to_reg;
    assign ex_ALUSrc   = ex_ctrl.alu_src;
    assign ex_Branch   = ex_ctrl.branch;
    assign ex_ALUOp    = ex_ctrl.alu_op;
    assign ex_illegal  = ex_ctrl.illegal;

endmodule
